// File: rtl/mod_step_counter.sv
// mod_step_counter: up/down counter over 0..MAX_VALUE with a programmable step.
// Bound handling is either modulo wrap or clamp (SATURATE). A registered
// one-cycle terminal_count pulse and a sticky overflow flag report bound hits.
module mod_step_counter #(
    parameter int WIDTH      = 8,
    parameter int MAX_VALUE  = 255,
    parameter int STEP_WIDTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    output logic [WIDTH-1:0]      counter_output,
    output logic                  terminal_count,
    output logic                  overflow_sticky
);

    // Two guard bits: one for the carry past 2**WIDTH-1 and one for the sign
    // of a down-count below zero, so r = cur +/- step never aliases.
    localparam int RW = WIDTH + 2;

    localparam logic signed [RW-1:0] MAX_S  = RW'(MAX_VALUE);
    localparam logic signed [RW-1:0] SPAN_S = RW'(MAX_VALUE + 1);
    localparam logic [WIDTH-1:0]     MAX_W  = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0]     count_q;
    logic                 tc_q;
    logic                 sticky_q;

    logic [WIDTH-1:0]     count_d;
    logic                 tc_d;
    logic                 sticky_d;

    logic signed [RW-1:0] cur_s;
    logic signed [RW-1:0] step_s;
    logic signed [RW-1:0] sum_s;
    logic signed [RW-1:0] wrap_s;
    logic                 step_zero;
    logic                 out_rng;
    logic                 at_bound;
    logic [WIDTH-1:0]     count_step;
    logic [WIDTH-1:0]     load_clamped;

    // Unbounded step result, range test and corrected value for a count op.
    always_comb begin
        cur_s     = {2'b00, count_q};
        step_s    = {{(RW-STEP_WIDTH){1'b0}}, step};
        step_zero = (step == '0);
        sum_s     = up_down ? (cur_s + step_s) : (cur_s - step_s);

        // Up overflows past MAX_VALUE; down underflows when the sign bit sets.
        if (up_down) begin
            out_rng  = (sum_s > MAX_S);
            at_bound = (sum_s == MAX_S);
            wrap_s   = sum_s - SPAN_S;
        end else begin
            out_rng  = sum_s[RW-1];
            at_bound = (sum_s == '0);
            wrap_s   = sum_s + SPAN_S;
        end

        // A single span correction always lands in range because the
        // largest step never exceeds MAX_VALUE+1.
        if (!out_rng) begin
            count_step = sum_s[WIDTH-1:0];
        end else if (SATURATE != 0) begin
            count_step = up_down ? MAX_W : '0;
        end else begin
            count_step = wrap_s[WIDTH-1:0];
        end
    end

    // Loaded values above the range are pinned to MAX_VALUE.
    always_comb begin
        if ({2'b00, load_value} > MAX_S) begin
            load_clamped = MAX_W;
        end else begin
            load_clamped = load_value;
        end
    end

    // Next-state selection: clear > load > count > hold.
    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        sticky_d = sticky_q;
        if (clear) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (enable && !step_zero) begin
            count_d = count_step;
            tc_d    = out_rng || at_bound;
            if (out_rng) begin
                sticky_d = 1'b1;
            end
        end
    end

    // State register; reset is asynchronous so it applies mid-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            tc_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            tc_q     <= tc_d;
            sticky_q <= sticky_d;
        end
    end

    assign counter_output  = count_q;
    assign terminal_count  = tc_q;
    assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_mod_step_counter.sv
// Bench for mod_step_counter: three configurations (default 0..255 wrap,
// decade wrap, decade saturate) share one stimulus stream. Directed vectors
// cover the corner cases; random traffic is checked against a reference model.
module tb_mod_step_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       enable;
    logic       up_down;
    logic [3:0] step;

    logic [7:0] cnt [3];
    logic       tc  [3];
    logic       st  [3];

    localparam int MAXV [3] = '{255, 9, 9};
    localparam int SATV [3] = '{0, 0, 1};
    localparam int SMSK [3] = '{15, 7, 7};

    int m_cnt [3];
    bit m_tc  [3];
    bit m_st  [3];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         inst;
        bit         clr;
        bit         ld;
        logic [7:0] lv;
        bit         en;
        bit         ud;
        logic [3:0] stp;
        int         e_cnt;
        bit         e_tc;
        bit         e_st;
    } vec_t;

    vec_t vq [$];

    always #5 clk = ~clk;

    mod_step_counter #(.WIDTH(8), .MAX_VALUE(255), .STEP_WIDTH(4), .SATURATE(0)) u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .step(step),
        .counter_output(cnt[0]), .terminal_count(tc[0]), .overflow_sticky(st[0]));

    mod_step_counter #(.WIDTH(8), .MAX_VALUE(9), .STEP_WIDTH(3), .SATURATE(0)) u_dec (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .step(step[2:0]),
        .counter_output(cnt[1]), .terminal_count(tc[1]), .overflow_sticky(st[1]));

    mod_step_counter #(.WIDTH(8), .MAX_VALUE(9), .STEP_WIDTH(3), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .step(step[2:0]),
        .counter_output(cnt[2]), .terminal_count(tc[2]), .overflow_sticky(st[2]));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: apply the counting rules with plain integer arithmetic.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int mx = MAXV[i];
            int s  = int'(step) & SMSK[i];
            int r;
            bit oor;
            if (!rst_n || clear) begin
                m_cnt[i] = 0; m_tc[i] = 0; m_st[i] = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_value) > mx) ? mx : int'(load_value);
                m_tc[i]  = 0;
            end else if (enable && s != 0) begin
                r   = up_down ? m_cnt[i] + s : m_cnt[i] - s;
                oor = (r > mx) || (r < 0);
                m_tc[i] = oor || (r == (up_down ? mx : 0));
                if (oor) m_st[i] = 1;
                if (!oor)           m_cnt[i] = r;
                else if (SATV[i])   m_cnt[i] = up_down ? mx : 0;
                else                m_cnt[i] = up_down ? r - (mx + 1) : r + (mx + 1);
            end else begin
                m_tc[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s i%0d cnt", tag, i), int'(cnt[i]), 0);
            chk($sformatf("%s i%0d tc", tag, i), int'(tc[i]), 0);
            chk($sformatf("%s i%0d sticky", tag, i), int'(st[i]), 0);
        end
    endtask

    function automatic void add(input int inst, input bit clr, input bit ld, input int lv,
                                input bit en, input bit ud, input int stp,
                                input int c, input bit t, input bit s);
        vec_t v;
        v.inst = inst; v.clr = clr; v.ld = ld; v.lv = 8'(lv);
        v.en = en; v.ud = ud; v.stp = 4'(stp);
        v.e_cnt = c; v.e_tc = t; v.e_st = s;
        vq.push_back(v);
    endfunction

    initial begin
        // Decade wrap up, step 3 from 0
        //   inst clr ld lv   en ud stp  cnt tc st
        add(1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        add(1, 0, 0, 0,   1, 1, 3,   3, 0, 0);
        add(1, 0, 0, 0,   1, 1, 3,   6, 0, 0);
        add(1, 0, 0, 0,   1, 1, 3,   9, 1, 0);
        add(1, 0, 0, 0,   1, 1, 3,   2, 1, 1);
        add(1, 0, 0, 0,   1, 1, 3,   5, 0, 1);
        // Wrap down, step 4 from 2
        add(1, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        add(1, 0, 1, 2,   0, 0, 0,   2, 0, 0);
        add(1, 0, 0, 0,   1, 0, 4,   8, 1, 1);
        add(1, 0, 0, 0,   1, 0, 4,   4, 0, 1);
        add(1, 0, 0, 0,   1, 0, 4,   0, 1, 1);
        // Saturate, step 5 from 7 up then down
        add(2, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        add(2, 0, 1, 7,   0, 0, 0,   7, 0, 0);
        add(2, 0, 0, 0,   1, 1, 5,   9, 1, 1);
        add(2, 0, 0, 0,   1, 1, 5,   9, 1, 1);
        add(2, 0, 0, 0,   1, 0, 5,   4, 0, 1);
        add(2, 0, 0, 0,   1, 0, 5,   0, 1, 1);
        // Priority: clear beats load and enable; load clamps
        add(1, 0, 1, 5,   0, 0, 0,   5, 0, 1);
        add(1, 1, 1, 5,   1, 1, 3,   0, 0, 0);
        add(1, 0, 1, 200, 0, 0, 0,   9, 0, 0);
        // Hold: enable low, then step 0 at the upper bound
        add(1, 0, 0, 0,   0, 1, 3,   9, 0, 0);
        add(1, 0, 0, 0,   0, 1, 3,   9, 0, 0);
        add(1, 0, 0, 0,   0, 1, 3,   9, 0, 0);
        add(1, 0, 0, 0,   1, 1, 0,   9, 0, 0);
        add(1, 0, 0, 0,   1, 1, 0,   9, 0, 0);
        add(1, 0, 0, 0,   1, 1, 0,   9, 0, 0);
        // Default config crossing 255
        add(0, 1, 0, 0,   0, 0, 0,   0, 0, 0);
        add(0, 0, 1, 254, 0, 0, 0, 254, 0, 0);
        add(0, 0, 0, 0,   1, 1, 1, 255, 1, 0);
        add(0, 0, 0, 0,   1, 1, 1,   0, 1, 1);

        rst_n = 1'b0; clear = 0; load = 0; load_value = '0;
        enable = 0; up_down = 0; step = '0;
        #3;
        chk_zero("reset");
        tick();
        rst_n = 1'b1;

        foreach (vq[k]) begin
            clear = vq[k].clr; load = vq[k].ld; load_value = vq[k].lv;
            enable = vq[k].en; up_down = vq[k].ud; step = vq[k].stp;
            tick();
            chk($sformatf("vec%0d cnt", k), int'(cnt[vq[k].inst]), vq[k].e_cnt);
            chk($sformatf("vec%0d tc", k), int'(tc[vq[k].inst]), int'(vq[k].e_tc));
            chk($sformatf("vec%0d sticky", k), int'(st[vq[k].inst]), int'(vq[k].e_st));
        end

        // Asynchronous reset while counting, then resume from 0
        clear = 1; load = 0; enable = 0;
        tick();
        clear = 0; enable = 1; up_down = 1; step = 4'd1;
        repeat (5) tick();
        chk("run cnt", int'(cnt[0]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("resume 1", int'(cnt[0]), 1);
        tick();
        chk("resume 2", int'(cnt[0]), 2);

        // Random traffic against the model on all three configurations
        for (int n = 0; n < 400; n++) begin
            clear      = ($urandom_range(31) == 0);
            load       = ($urandom_range(15) == 0);
            load_value = 8'($urandom);
            enable     = ($urandom_range(3) != 0);
            up_down    = 1'($urandom);
            step       = 4'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd%0d i%0d cnt", n, i), int'(cnt[i]), m_cnt[i]);
                chk($sformatf("rnd%0d i%0d tc", n, i), int'(tc[i]), int'(m_tc[i]));
                chk($sformatf("rnd%0d i%0d sticky", n, i), int'(st[i]), int'(m_st[i]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
